// File: rtl/mcp_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcp_arb_pkg
// Purpose  : Shared definitions for the MCP-channel arbiter: the FSM state
//            encodings and a constant-foldable ceiling-log2 helper used to
//            size index and counter vectors.
// Ports    : (package - none)
// Revision : 1.0 - initial release
// ============================================================================
package mcp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Ceiling log2, floored at 1 so a vector sized by it is never zero-width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage : mcp_arb_pkg
`default_nettype wire

// File: rtl/mcp_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Searches req starting at ptr,
//            wrapping modulo N, and reports the first set requester.
// Ports    : req    in  N    request vector
//            ptr    in  IDW  search start index (0..N-1)
//            onehot out N    one-hot winner (zero when no request)
//            idx    out IDW  winner index (zero when no request)
//            any    out 1    at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [IDW-1:0] w_pos;

  // Walk offsets from farthest to nearest so the nearest set bit (relative
  // to ptr) is the last one assigned and therefore wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    w_pos  = '0;
    any    = |req;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = IDW'((int'(ptr) + k) % N);
      if (req[w_pos]) begin
        onehot        = '0;
        onehot[w_pos] = 1'b1;
        idx           = w_pos;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mcp_arb.sv
`default_nettype none
// ============================================================================
// Module   : mcp_arb
// Purpose  : Round-robin arbiter feeding a multi-cycle-path channel. A winner
//            is launched with a one-cycle aen/gnt pulse, then the arbiter
//            stays busy so launches are spaced at least GAP cycles apart.
// Ports    : aclk   in  1     clock (rising edge)
//            arst_n in  1     asynchronous active-low reset
//            en     in  1     arbitration enable
//            req    in  N     per-requester level request
//            data   in  N*DW  per-requester payload, slice [i*DW +: DW]
//            gnt    out N     one-hot one-cycle grant
//            aen    out 1     one-cycle MCP launch pulse (flop)
//            adata  out DW    winner payload, held until next launch (flop)
//            aid    out IDW   winner index, held until next launch (flop)
//            busy   out 1     high while in LAUNCH or HOLD
// Revision : 1.0 - initial release
// ============================================================================
module mcp_arb
  import mcp_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int DW  = 8,
  parameter int GAP = 8,
  localparam int IDW = clog2(N)
) (
  input  logic            aclk,
  input  logic            arst_n,
  input  logic            en,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] data,
  output logic [N-1:0]    gnt,
  output logic            aen,
  output logic [DW-1:0]   adata,
  output logic [IDW-1:0]  aid,
  output logic            busy
);

  // HOLD lasts GAP-2 cycles; with LAUNCH and the one IDLE sampling cycle the
  // launch period under continuous requests is exactly GAP.
  localparam int c_HOLD_CYC = GAP - 2;
  localparam int CW         = clog2(GAP);
  localparam int c_LOAD     = (c_HOLD_CYC > 0) ? (c_HOLD_CYC - 1) : 0;

  generate
    if (GAP < 2) begin : g_bad_gap
      $error("mcp_arb: GAP must be at least 2");
    end
    if ((N < 2) || (N > 16)) begin : g_bad_n
      $error("mcp_arb: N must be in 2..16");
    end
  endgenerate

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [IDW-1:0] r_ptr, w_ptr_nxt;
  logic           r_aen;
  logic [N-1:0]   r_gnt;
  logic [DW-1:0]  r_adata;
  logic [IDW-1:0] r_aid;

  logic           w_launch;
  logic [N-1:0]   w_onehot;
  logic [IDW-1:0] w_idx;
  logic           w_any;
  logic [DW-1:0]  w_win_data;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req    (req),
    .ptr    (r_ptr),
    .onehot (w_onehot),
    .idx    (w_idx),
    .any    (w_any)
  );

  // AND-OR payload mux driven by the one-hot winner.
  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_onehot[i]) w_win_data = data[i*DW +: DW];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_launch    = 1'b0;
    w_ptr_nxt   = (w_idx == IDW'(N - 1)) ? '0 : w_idx + IDW'(1);
    case (r_state)
      IDLE: begin
        if (en && w_any) begin
          w_launch    = 1'b1;
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        if (c_HOLD_CYC == 0) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = CW'(c_LOAD);
        end
      end
      HOLD: begin
        if (r_cnt == '0) w_state_nxt = IDLE;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_aen   <= 1'b0;
      r_gnt   <= '0;
      r_adata <= '0;
      r_aid   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_aen   <= w_launch;
      r_gnt   <= w_launch ? w_onehot : '0;
      if (w_launch) begin
        r_ptr   <= w_ptr_nxt;
        r_adata <= w_win_data;
        r_aid   <= w_idx;
      end
    end
  end

  assign gnt   = r_gnt;
  assign aen   = r_aen;
  assign adata = r_adata;
  assign aid   = r_aid;
  assign busy  = (r_state != IDLE);

endmodule : mcp_arb
`default_nettype wire

// File: tb/tb_mcp_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcp_arb
// Purpose  : Self-checking bench for mcp_arb (N=4, DW=8, GAP=6): directed
//            scenarios plus randomized traffic against a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcp_arb;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int GAP = 6;

  logic          aclk = 1'b0;
  logic          arst_n;
  logic          en;
  logic [N-1:0]  req;
  logic [31:0]   data;
  logic [N-1:0]  gnt;
  logic          aen;
  logic [DW-1:0] adata;
  logic [1:0]    aid;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: "remaining busy cycles" plus round-robin pointer.
  int         m_ptr, m_rem;
  logic       m_aen;
  logic [3:0] m_gnt;
  logic [7:0] m_adata;
  logic [1:0] m_aid;
  logic       m_busy;

  always #5 aclk = ~aclk;

  mcp_arb #(.N(N), .DW(DW), .GAP(GAP)) dut (
    .aclk   (aclk),
    .arst_n (arst_n),
    .en     (en),
    .req    (req),
    .data   (data),
    .gnt    (gnt),
    .aen    (aen),
    .adata  (adata),
    .aid    (aid),
    .busy   (busy)
  );

  task automatic model_reset();
    m_ptr = 0; m_rem = 0; m_aen = 0; m_gnt = '0;
    m_adata = '0; m_aid = '0; m_busy = 0;
  endtask

  // Applied at each rising edge using the inputs present at that edge.
  task automatic model_edge();
    int rq, w;
    rq = int'(req);
    w  = -1;
    if (m_rem == 0 && en && rq != 0) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && ((rq >> ((m_ptr + k) % N)) & 1) == 1) w = (m_ptr + k) % N;
      end
      m_aen   = 1'b1;
      m_gnt   = 4'(1 << w);
      m_adata = 8'(data >> (w * 8));
      m_aid   = 2'(w);
      m_ptr   = (w + 1) % N;
      m_rem   = GAP - 1;
    end else begin
      m_aen = 1'b0;
      m_gnt = '0;
      if (m_rem > 0) m_rem--;
    end
    m_busy = (m_rem > 0);
  endtask

  task automatic tick();
    @(posedge aclk);
    model_edge();
    @(negedge aclk);
  endtask

  task automatic do_reset();
    arst_n = 1'b0; en = 1'b0; req = '0; data = '0;
    repeat (2) @(negedge aclk);
    model_reset();
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; en = 1'b0; req = '0; data = '0;
    #1;
    n_cmp++;
    if ({aen, gnt, adata, aid, busy} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0000", {aen, gnt, adata, aid, busy});
    end
    @(negedge aclk);
    model_reset();
    arst_n = 1'b1;
    tick();
    n_cmp++;
    if ({aen, gnt, busy} !== 6'h0) begin
      n_err++;
      $display("FAIL reset_idle: got %h expected 00", {aen, gnt, busy});
    end
  endtask

  task automatic test_single();
    int busy_cnt, aen_cnt;
    do_reset();
    en = 1'b1; data[23:16] = 8'hA5; req = 4'b0100;
    tick();
    n_cmp++;
    if ({aen, gnt, adata, aid, busy} !== {1'b1, 4'b0100, 8'hA5, 2'd2, 1'b1}) begin
      n_err++;
      $display("FAIL single_launch: got %h expected %h", {aen, gnt, adata, aid, busy},
               {1'b1, 4'b0100, 8'hA5, 2'd2, 1'b1});
    end
    req = '0; busy_cnt = 1; aen_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (busy) busy_cnt++;
      if (aen)  aen_cnt++;
    end
    n_cmp++;
    if (busy_cnt != GAP - 1) begin
      n_err++;
      $display("FAIL single_busy_len: got %0d expected %0d", busy_cnt, GAP - 1);
    end
    n_cmp++;
    if (aen_cnt != 0 || adata !== 8'hA5 || aid !== 2'd2) begin
      n_err++;
      $display("FAIL single_hold: got aen_cnt=%0d adata=%h aid=%0d expected 0 a5 2",
               aen_cnt, adata, aid);
    end
  endtask

  task automatic test_round_robin();
    int times[$];
    int ids[$];
    int prev_aen;
    do_reset();
    en = 1'b1; data = 32'h44332211; req = 4'b1111; prev_aen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (aen) begin
        times.push_back(c);
        ids.push_back(int'(aid));
        n_cmp++;
        if (gnt !== 4'(1 << aid) || adata !== 8'(data >> (8 * aid)) || prev_aen != 0) begin
          n_err++;
          $display("FAIL rr_pulse: got gnt=%b adata=%h prev_aen=%0d expected onehot of aid=%0d",
                   gnt, adata, prev_aen, aid);
        end
      end
      prev_aen = int'(aen);
    end
    n_cmp++;
    if (times.size() != 5) begin
      n_err++;
      $display("FAIL rr_count: got %0d expected 5", times.size());
    end
    for (int k = 0; k < times.size(); k++) begin
      n_cmp++;
      if (ids[k] != k % N || times[k] != k * GAP) begin
        n_err++;
        $display("FAIL rr_order[%0d]: got id=%0d t=%0d expected id=%0d t=%0d",
                 k, ids[k], times[k], k % N, k * GAP);
      end
    end
  endtask

  task automatic test_hold_new();
    int cyc;
    do_reset();
    en = 1'b1; data = 32'hD0C0B0A0; req = 4'b0010;
    tick();
    n_cmp++;
    if (aen !== 1'b1 || aid !== 2'd1) begin
      n_err++;
      $display("FAIL hold_first: got aen=%b aid=%0d expected 1 1", aen, aid);
    end
    cyc = 0;
    for (int c = 0; c < 20; c++) begin
      tick(); cyc++;
      if (cyc == 1) req = 4'b1010;
      if (aen) break;
    end
    n_cmp++;
    if (aen !== 1'b1 || aid !== 2'd3 || gnt !== 4'b1000 || cyc != GAP) begin
      n_err++;
      $display("FAIL hold_to_3: got aen=%b aid=%0d gnt=%b cyc=%0d expected 1 3 1000 %0d",
               aen, aid, gnt, cyc, GAP);
    end
    req = 4'b0010; cyc = 0;
    for (int c = 0; c < 20; c++) begin
      tick(); cyc++;
      if (aen) break;
    end
    n_cmp++;
    if (aen !== 1'b1 || aid !== 2'd1 || adata !== 8'hB0 || cyc != GAP) begin
      n_err++;
      $display("FAIL hold_back_to_1: got aen=%b aid=%0d adata=%h cyc=%0d expected 1 1 b0 %0d",
               aen, aid, adata, cyc, GAP);
    end
  endtask

  task automatic test_withdraw();
    int aen_cnt, g0_cnt;
    do_reset();
    en = 1'b1; req = 4'b0100;
    tick();
    req = '0;    tick();
    req = 4'b0001; tick(); tick();
    req = '0;
    aen_cnt = 0; g0_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (aen)    aen_cnt++;
      if (gnt[0]) g0_cnt++;
    end
    n_cmp++;
    if (aen_cnt != 0 || g0_cnt != 0) begin
      n_err++;
      $display("FAIL withdraw: got aen_cnt=%0d gnt0_cnt=%0d expected 0 0", aen_cnt, g0_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1; data = 32'h0000_7700; req = 4'b0100;
    tick();
    req = '0; tick(); tick();
    #2 arst_n = 1'b0;
    #1;
    n_cmp++;
    if ({aen, gnt, adata, aid, busy} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_mid_async: got %h expected 0000", {aen, gnt, adata, aid, busy});
    end
    req = 4'b1001; data = 32'h5500_00EE;
    repeat (2) @(negedge aclk);
    model_reset();
    arst_n = 1'b1;
    tick();
    n_cmp++;
    if ({aen, gnt, adata, aid} !== {1'b1, 4'b0001, 8'hEE, 2'd0}) begin
      n_err++;
      $display("FAIL reset_mid_first: got %h expected %h", {aen, gnt, adata, aid},
               {1'b1, 4'b0001, 8'hEE, 2'd0});
    end
  endtask

  task automatic test_enable();
    int aen_cnt;
    do_reset();
    en = 1'b0; req = 4'b0010; data = 32'h0000_3C00;
    aen_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (aen || busy) aen_cnt++;
    end
    n_cmp++;
    if (aen_cnt != 0) begin
      n_err++;
      $display("FAIL enable_block: got %0d active cycles expected 0", aen_cnt);
    end
    en = 1'b1;
    tick();
    n_cmp++;
    if ({aen, gnt, adata} !== {1'b1, 4'b0010, 8'h3C}) begin
      n_err++;
      $display("FAIL enable_launch: got %h expected %h", {aen, gnt, adata}, {1'b1, 4'b0010, 8'h3C});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (m_gnt[i]) begin
            if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
          end else if ($urandom_range(99, 0) < 3) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(99, 0) < 20) begin
          req[i] = 1'b1;
          data[i*8 +: 8] = 8'($urandom);
        end
      end
      en = ($urandom_range(99, 0) < 85);
      tick();
      n_cmp++;
      if ({aen, gnt, adata, aid, busy} !== {m_aen, m_gnt, m_adata, m_aid, m_busy}) begin
        n_err++;
        $display("FAIL random[%0d]: got aen=%b gnt=%b adata=%h aid=%0d busy=%b expected %b %b %h %0d %b",
                 c, aen, gnt, adata, aid, busy, m_aen, m_gnt, m_adata, m_aid, m_busy);
      end
    end
  endtask

  initial begin
    arst_n = 1'b0; en = 1'b0; req = '0; data = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_hold_new();
    test_withdraw();
    test_reset_mid();
    test_enable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mcp_arb
`default_nettype wire

// File: doc/mcp_arb.md
MCP_ARB -- requirements
Module: mcp_arb

Interface
REQ-001 Parameter N, default 4: number of requesters sharing one multi-cycle-path (MCP) channel; legal range 2..16.
REQ-002 Parameter DW, default 8: payload width per requester.
REQ-003 Parameter GAP, default 8: minimum aclk cycles between consecutive aen pulses; GAP<2 SHALL fail elaboration.
REQ-004 Parameter IDW, derived as clog2(N): requester-index width.
REQ-005 aclk  in  1  single clock; all logic rising-edge on aclk.
REQ-006 arst_n  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  arbitration enable; low blocks new grants.
REQ-008 req  in  N  per-requester level request; held until granted.
REQ-009 data  in  N*DW  per-requester payload; requester i uses slice [i*DW +: DW]; stable while req[i] is high.
REQ-010 gnt  out  N  one-hot, one-cycle grant pulse.
REQ-011 aen  out  1  one-cycle launch pulse to the MCP channel enable.
REQ-012 adata  out  DW  registered winner payload, valid with aen and held until the next launch.
REQ-013 aid  out  IDW  registered winner index, valid with aen and held until the next launch.
REQ-014 busy  out  1  high in LAUNCH and HOLD.

Function
REQ-015 FSM states SHALL be IDLE, LAUNCH and HOLD.
REQ-016 IDLE: at an edge where en=1 and req!=0, the winner SHALL be picked round-robin and the FSM SHALL go to LAUNCH; otherwise it stays in IDLE.
REQ-017 Round-robin search SHALL start at index ptr and wrap modulo N; ptr SHALL update to (winner+1) mod N on each launch.
REQ-018 LAUNCH (exactly 1 cycle): aen=1, gnt[winner]=1, adata=winner payload, aid=winner index.
REQ-019 Latency: req sampled high in IDLE at edge k -> aen/gnt high in the cycle following edge k.
REQ-020 HOLD: a down-counter SHALL hold the FSM for GAP-2 cycles, then return to IDLE, so continuous requests yield aen exactly every GAP cycles.
REQ-021 During LAUNCH and HOLD, req and en SHALL be ignored.
REQ-022 A req deasserted before being sampled in IDLE SHALL be withdrawn without a grant.
REQ-023 A granted requester keeping req high SHALL be treated as a new request, arbitrated fairly against the others.
REQ-024 en falling during LAUNCH or HOLD SHALL NOT abort the sequence; the sequence completes and the FSM then waits in IDLE.
REQ-025 gnt SHALL be zero outside LAUNCH; aen and gnt SHALL never be high in consecutive cycles.
REQ-026 adata and aid SHALL change only on a launch edge.

Reset
REQ-027 arst_n low SHALL asynchronously force: state=IDLE, ptr=0, counter=0, aen=0, gnt=0, adata=0, aid=0, busy=0.
REQ-028 Reset asserted mid-LAUNCH or mid-HOLD SHALL abandon the transfer with no further pulse; the first arbitration after release SHALL start at index 0.

Structure
REQ-029 Package mcp_arb_pkg SHALL hold the state encodings (IDLE, LAUNCH, HOLD) and the clog2 function.
REQ-030 Sub-module rr_pick (combinational: req, ptr -> one-hot winner, index, any) SHALL be the only child.
REQ-031 aen, adata and aid SHALL be flop outputs, so they drive the MCP source register without glue logic.

Verification (N=4, DW=8, GAP=6)
REQ-032 Single request: req=0100, data[2]=0xA5 sampled at edge 10 -> cycle 11 aen=1, gnt=0100, adata=0xA5, aid=2; busy cycles 11-15; IDLE at edge 16.
REQ-033 req=1111 held -> grants in order 0,1,2,3,0 with aen at cycles T, T+6, T+12, T+18, T+24.
REQ-034 req[1] granted and held, req[3] raised during HOLD -> next grant goes to 3 (ptr=2), then to 1.
REQ-035 req[0] pulsed only during HOLD and dropped before IDLE -> no gnt[0] and no aen.
REQ-036 arst_n low at HOLD cycle 2 -> all outputs 0 immediately; after release with req=1001 -> first grant goes to 0.
REQ-037 en=0 with req=0010 for 20 cycles -> no aen; en raised at edge k -> aen, gnt=0010 in the cycle following edge k.
